wrr_req_mux: RTL and testbench

Grant-driven request multiplexer that sits directly downstream of the weighted round-robin arbiter in the memory manager. It samples the arbiter's registered one-hot grant, captures the granted requester's transaction, and issues it on the single shared memory port with a valid/ready handshake. It tracks the single outstanding transaction and routes the memory response back to the originating requester.

---
 rtl/wrr_req_mux.sv | 140 ++++++++++++++
 tb/tb_wrr_req_mux.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrr_req_mux.sv
`default_nettype none
// =============================================================================
// wrr_req_mux : captures the arbiter-granted transaction, issues it on the
//   shared memory port and steers the response back to its requester.
//   Optional response timeout: define WRR_MUX_TIMEOUT_EN.
// Rev 1.0
// =============================================================================
module wrr_req_mux #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        grant_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      mem_valid_o,
  input  logic                      mem_ready_i,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic                      busy_o
);

  localparam int c_id_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_id_w-1:0]   r_id;
  logic [c_id_w-1:0]   w_idx;
  logic                w_onehot;
  logic                w_accept;

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_i[k]) w_idx = c_id_w'(k);
    end
  end

  // Multi-hot or empty grants are never acted on, even if a requester is valid.
  assign w_onehot = (grant_i != '0) && ((grant_i & (grant_i - NUM_REQ'(1))) == '0);
  assign w_accept = w_onehot && ((grant_i & req_valid_i) != '0);

`ifdef WRR_MUX_TIMEOUT_EN
  localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_expire;
  assign w_expire = (r_cnt == c_cnt_last);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_id        <= '0;
      req_ready_o <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      busy_o      <= 1'b0;
`ifdef WRR_MUX_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      req_ready_o <= '0;
      rsp_valid_o <= '0;
      rsp_err_o   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id        <= w_idx;
            mem_we_o    <= req_we_i[w_idx];
            mem_addr_o  <= req_addr_i[w_idx*ADDR_W +: ADDR_W];
            mem_wdata_o <= req_wdata_i[w_idx*DATA_W +: DATA_W];
            req_ready_o <= grant_i;
            mem_valid_o <= 1'b1;
            busy_o      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            r_state     <= S_WAIT;
`ifdef WRR_MUX_TIMEOUT_EN
            r_cnt       <= '0;
`endif
          end
        end
        S_WAIT: begin
          // A real response on the expiry edge takes priority over the timeout.
          if (mem_rvalid_i) begin
            rsp_rdata_o <= mem_rdata_i;
            rsp_valid_o <= NUM_REQ'(1) << r_id;
            busy_o      <= 1'b0;
            r_state     <= S_IDLE;
          end
`ifdef WRR_MUX_TIMEOUT_EN
          else if (w_expire) begin
            rsp_rdata_o <= '0;
            rsp_valid_o <= NUM_REQ'(1) << r_id;
            rsp_err_o   <= 1'b1;
            busy_o      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          mem_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wrr_req_mux.sv
`default_nettype none
// tb_wrr_req_mux : directed bench for wrr_req_mux; a transaction-level model is
// checked against the DUT every cycle, plus hand-computed literal checks.
module tb_wrr_req_mux;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NR-1:0]    grant = '0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_we = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             mem_valid;
  logic             mem_ready = 1'b0;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic             mem_rvalid = 1'b0;
  logic [DW-1:0]    mem_rdata = '0;
  logic             busy;

  wrr_req_mux #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .grant_i(grant), .req_valid_i(req_valid),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [NR-1:0] g);
    idx_of = 0;
    for (int k = 0; k < NR; k++) if (g[k]) idx_of = k;
  endfunction

  // Transaction-level model: one owned transaction, first on the bus, then
  // awaiting its response (or a timeout after TO silent waiting cycles).
  bit            m_own, m_on_bus;
  int            m_id, m_waited;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [NR-1:0] e_ready, e_rsp;
  logic          e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_own <= 0; m_on_bus <= 0; m_id <= 0; m_waited <= 0;
      m_we <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
      e_ready <= '0; e_rsp <= '0; e_err <= 1'b0;
    end else begin
      e_ready <= '0; e_rsp <= '0; e_err <= 1'b0;
      if (!m_own) begin
        if ($countones(grant) == 1 && (grant & req_valid) != '0) begin
          m_id     <= idx_of(grant);
          m_we     <= req_we[idx_of(grant)];
          m_addr   <= req_addr[idx_of(grant)*AW +: AW];
          m_wdata  <= req_wdata[idx_of(grant)*DW +: DW];
          e_ready  <= grant;
          m_own    <= 1;
          m_on_bus <= 1;
        end
      end else if (m_on_bus) begin
        if (mem_ready) begin
          m_on_bus <= 0;
          m_waited <= 0;
        end
      end else if (mem_rvalid) begin
        m_rdata <= mem_rdata;
        e_rsp   <= NR'(1) << m_id;
        m_own   <= 0;
      end else begin
        m_waited <= m_waited + 1;
`ifdef WRR_MUX_TIMEOUT_EN
        if (m_waited + 1 == TO) begin
          m_rdata <= '0;
          e_rsp   <= NR'(1) << m_id;
          e_err   <= 1'b1;
          m_own   <= 0;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_req_ready", req_ready, e_ready);
      chk("m_rsp_valid", rsp_valid, e_rsp);
      chk("m_rsp_err",   rsp_err,   e_err);
      chk("m_rsp_rdata", rsp_rdata, m_rdata);
      chk("m_mem_valid", mem_valid, m_own && m_on_bus);
      chk("m_mem_we",    mem_we,    m_we);
      chk("m_mem_addr",  mem_addr,  m_addr);
      chk("m_mem_wdata", mem_wdata, m_wdata);
      chk("m_busy",      busy,      m_own);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int vcount;
  logic [15:0] acc_mask, rsp_mask, rsp0_mask;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_mem_valid", mem_valid, 0);
    chk("reset_busy",      busy,      0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_mem_addr",  mem_addr,  0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Read from requester 0
    @(negedge clk);
    grant = 2'b01; req_valid = 2'b01; req_we = 2'b00;
    req_addr[0 +: AW] = 32'h100; mem_ready = 1'b1;
    @(negedge clk);
    chk("rd_req_ready", req_ready, 2'b01);
    chk("rd_mem_valid", mem_valid, 1);
    chk("rd_mem_addr",  mem_addr,  32'h100);
    chk("rd_mem_we",    mem_we,    0);
    grant = '0; req_valid = '0;
    @(negedge clk);
    chk("rd_mem_valid_fall", mem_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rd_rsp_valid", rsp_valid, 2'b01);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_busy_done", busy, 0);
    mem_rvalid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("rd_rsp_pulse",  rsp_valid, 0);
    chk("rd_rdata_hold", rsp_rdata, 32'hDEADBEEF);

    // Write from requester 1 with memory stalling four cycles
    grant = 2'b10; req_valid = 2'b10; req_we = 2'b10;
    req_addr[AW +: AW] = 32'h200; req_wdata[DW +: DW] = 32'h55AA;
    vcount = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_valid) vcount++;
      if (i == 1) begin
        chk("wr_req_ready", req_ready, 2'b10);
        chk("wr_mem_we",    mem_we,    1);
        chk("wr_mem_wdata", mem_wdata, 32'h55AA);
        grant = '0; req_valid = '0;
      end
      if (i == 5) mem_ready = 1'b1;
      if (i == 6) begin mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234; end
      if (i == 7) begin chk("wr_rsp_valid", rsp_valid, 2'b10); mem_rvalid = 1'b0; end
    end
    chk("wr_mem_valid_cycles", vcount, 5);

    // Multi-hot and empty grants are ignored
    grant = 2'b11; req_valid = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("bad_req_ready", req_ready, 0);
      chk("bad_mem_valid", mem_valid, 0);
      chk("bad_busy",      busy,      0);
      if (i == 2) grant = 2'b00;
    end
    req_valid = '0;

    // Grant held on requester 1 for three back-to-back transactions
    @(negedge clk);
    grant = 2'b10; req_valid = 2'b10; req_we = 2'b00;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    acc_mask = '0; rsp_mask = '0; rsp0_mask = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (req_ready[1]) acc_mask[i] = 1'b1;
      if (rsp_valid[1]) rsp_mask[i] = 1'b1;
      if (rsp_valid[0]) rsp0_mask[i] = 1'b1;
      if (i == 9) begin grant = '0; req_valid = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; end
    end
    chk("b2b_accept_cycles", acc_mask, 16'h0092);
    chk("b2b_rsp_cycles",    rsp_mask, 16'h0248);
    chk("b2b_rsp_wrong_id",  rsp0_mask, 16'h0000);

`ifdef WRR_MUX_TIMEOUT_EN
    // No response: timeout after eight waiting cycles
    grant = 2'b01; req_valid = 2'b01; req_addr[0 +: AW] = 32'h400; mem_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin grant = '0; req_valid = '0; end
      if (i == 2) mem_ready = 1'b0;
      if (i == 9) begin
        chk("to_busy_before", busy, 1);
        chk("to_no_rsp_yet",  rsp_valid, 0);
      end
      if (i == 10) begin
        chk("to_rsp_valid", rsp_valid, 2'b01);
        chk("to_rsp_err",   rsp_err,   1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_busy_done", busy,      0);
      end
    end

    // Response on the expiry edge wins
    grant = 2'b01; req_valid = 2'b01; mem_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin grant = '0; req_valid = '0; end
      if (i == 2) mem_ready = 1'b0;
      if (i == 9) begin mem_rvalid = 1'b1; mem_rdata = 32'hABCD; end
      if (i == 10) begin
        chk("to_edge_rsp_valid", rsp_valid, 2'b01);
        chk("to_edge_rsp_err",   rsp_err,   0);
        chk("to_edge_rsp_rdata", rsp_rdata, 32'hABCD);
        mem_rvalid = 1'b0;
      end
    end
`endif

    // Reset while waiting for a response
    grant = 2'b01; req_valid = 2'b01; req_addr[0 +: AW] = 32'h300; mem_ready = 1'b1;
    @(negedge clk);
    grant = '0; req_valid = '0;
    @(negedge clk);
    chk("rst_busy_before", busy, 1);
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("rst_no_rsp",   rsp_valid, 0);
    chk("rst_no_rdata", rsp_rdata, 0);
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_no_rsp_late", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
